// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl: frames receiver bytes as SYNC/LEN/payload/CSUM, holds a verified payload for valid/ack random-access read, reports errors
module uart_rx_packet_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         AW             = 4,
  parameter int         TIMEOUT_CYCLES = 1_041_600
) (
  input  logic          clk_100MHZ,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_flag,
  output logic          rx_clear,
  output logic          packet_valid,
  input  logic          packet_ack,
  output logic [AW:0]   pkt_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_csum,
  output logic          err_len,
  output logic          err_timeout,
  output logic [7:0]    err_count,
  output logic [7:0]    overrun_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, HOLD} state_t;
  state_t        state_q;
  logic          clr_pending_q;
  logic [AW:0]   len_q;
  logic [AW-1:0] idx_q;
  logic [7:0]    csum_q;
  logic [TW-1:0] tmr_q;
  logic [7:0]    mem_q [2**AW];
  logic          accept, timed, len_ok, last, e_len, e_csum, e_tmo;
  always_comb begin
    accept  = rx_flag && !clr_pending_q;
    timed   = state_q inside {LEN, PAYLOAD, CSUM};
    len_ok  = rx_data != 8'd0 && rx_data <= 8'(MAX_LEN);
    last    = {1'b0, idx_q} == len_q - 1'b1;
    e_len   = accept && state_q == LEN && !len_ok;
    e_csum  = accept && state_q == CSUM && rx_data != csum_q;
    e_tmo   = timed && !accept && tmr_q == TW'(TIMEOUT_CYCLES - 1);
    rd_data = (packet_valid && {1'b0, rd_addr} < pkt_len) ? mem_q[rd_addr] : 8'h00;
  end
  always_ff @(posedge clk_100MHZ) begin
    if (reset) begin
      state_q       <= IDLE;
      clr_pending_q <= 1'b0;
      rx_clear      <= 1'b0;
      packet_valid  <= 1'b0;
      pkt_len       <= '0;
      err_csum      <= 1'b0;
      err_len       <= 1'b0;
      err_timeout   <= 1'b0;
      err_count     <= 8'd0;
      overrun_count <= 8'd0;
      len_q         <= '0;
      idx_q         <= '0;
      csum_q        <= 8'd0;
      tmr_q         <= '0;
    end else begin
      rx_clear      <= accept;
      clr_pending_q <= accept || (clr_pending_q && rx_flag);
      err_len       <= e_len;
      err_csum      <= e_csum;
      err_timeout   <= e_tmo;
      if ((e_len || e_csum || e_tmo) && err_count != 8'hFF) err_count <= err_count + 8'd1;
      tmr_q <= (timed && !accept) ? tmr_q + 1'b1 : '0;
      if (e_tmo) state_q <= IDLE;
      else if (accept)
        case (state_q)
          IDLE: if (rx_data == SYNC_BYTE) state_q <= LEN;
          LEN: begin
            state_q <= len_ok ? PAYLOAD : IDLE;
            len_q   <= rx_data[AW:0];
            csum_q  <= rx_data;
            idx_q   <= '0;
          end
          PAYLOAD: begin
            csum_q <= csum_q + rx_data;
            idx_q  <= idx_q + 1'b1;
            if (last) state_q <= CSUM;
          end
          CSUM: begin
            state_q      <= e_csum ? IDLE : HOLD;
            packet_valid <= !e_csum;
            if (!e_csum) pkt_len <= len_q;
          end
          HOLD: if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
          default: state_q <= IDLE;
        endcase
      if (state_q == HOLD && packet_ack) begin
        state_q      <= IDLE;
        packet_valid <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk_100MHZ)
    if (accept && state_q == PAYLOAD) mem_q[idx_q] <= rx_data;
endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// tb_uart_rx_packet_ctrl: table, directed and randomized checks of uart_rx_packet_ctrl against a byte-level packet model
module tb_uart_rx_packet_ctrl;
  localparam int T       = 100;
  localparam int AW      = 4;
  localparam int MAX_LEN = 16;
  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_flag;
  logic          rx_clear;
  logic          packet_valid;
  logic          packet_ack;
  logic [AW:0]   pkt_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_csum, err_len, err_timeout;
  logic [7:0]    err_count, overrun_count;
  always #5 clk = ~clk;
  uart_rx_packet_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .AW(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk_100MHZ(clk), .reset(reset), .rx_data(rx_data), .rx_flag(rx_flag), .rx_clear(rx_clear),
    .packet_valid(packet_valid), .packet_ack(packet_ack), .pkt_len(pkt_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .err_csum(err_csum), .err_len(err_len), .err_timeout(err_timeout),
    .err_count(err_count), .overrun_count(overrun_count));
  int checks, failures, cyc;
  int n_clr, n_csum, n_len, n_tmo;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    n_clr  <= n_clr + int'(rx_clear);
    n_csum <= n_csum + int'(err_csum);
    n_len  <= n_len + int'(err_len);
    n_tmo  <= n_tmo + int'(err_timeout);
  end
  logic [7:0] fr[$];
  logic [7:0] m_pay[$];
  bit         m_hold;
  int         last_acc, m_errcnt, m_ovr, m_nclr;
  int         mp[3];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  function automatic void m_err(input int kind);
    mp[kind]++;
    if (m_errcnt < 255) m_errcnt++;
  endfunction
  function automatic void m_expire(input int quiet);
    if (fr.size() > 0 && quiet >= T) begin
      fr.delete();
      m_err(2);
    end
  endfunction
  function automatic void m_byte(input logic [7:0] b, input int at);
    int s;
    m_nclr++;
    if (m_hold) begin
      if (m_ovr < 255) m_ovr++;
      return;
    end
    m_expire(at - last_acc - 1);
    last_acc = at;
    if (fr.size() == 0) begin
      if (b == 8'hA5) fr.push_back(b);
      return;
    end
    fr.push_back(b);
    if (fr.size() == 2) begin
      if (b == 8'd0 || b > 8'(MAX_LEN)) begin
        fr.delete();
        m_err(1);
      end
      return;
    end
    if (fr.size() == int'(fr[1]) + 3) begin
      s = 0;
      for (int i = 1; i < fr.size() - 1; i++) s += int'(fr[i]);
      if (8'(s) == b) begin
        m_hold = 1;
        m_pay.delete();
        for (int i = 2; i < fr.size() - 1; i++) m_pay.push_back(fr[i]);
      end else m_err(0);
      fr.delete();
    end
  endfunction
  function automatic void m_reset();
    fr.delete();
    m_hold   = 0;
    m_errcnt = 0;
    m_ovr    = 0;
  endfunction
  function automatic int g();
    return ($urandom_range(0, 99) < 97) ? int'($urandom_range(0, 2)) : T - 3 + int'($urandom_range(0, 3));
  endfunction
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input int pre);
    repeat (pre) @(negedge clk);
    rx_data = b;
    rx_flag = 1'b1;
    @(negedge clk);
    m_byte(b, cyc);
    chk("rx_clear_after_accept", int'(rx_clear), 1);
    rx_flag = 1'b0;
    rx_data = 8'($urandom);
    @(negedge clk);
  endtask
  task automatic ack();
    packet_ack = 1'b1;
    @(negedge clk);
    packet_ack = 1'b0;
    chk("ack_release", int'(packet_valid), 0);
    m_hold = 0;
  endtask
  task automatic checkpoint(input string tag);
    idle(T + 2);
    m_expire(cyc - last_acc);
    chk({tag, ":valid"}, int'(packet_valid), int'(m_hold));
    if (m_hold) chk({tag, ":len"}, int'(pkt_len), m_pay.size());
    for (int i = 0; i < 2**AW; i++) begin
      @(negedge clk);
      rd_addr = AW'(i);
      #1;
      chk({tag, ":rd"}, int'(rd_data), (m_hold && i < m_pay.size()) ? int'(m_pay[i]) : 0);
    end
    chk({tag, ":err_count"}, int'(err_count), m_errcnt);
    chk({tag, ":overrun"}, int'(overrun_count), m_ovr);
    chk({tag, ":clears"}, n_clr, m_nclr);
    chk({tag, ":csum_pulses"}, n_csum, mp[0]);
    chk({tag, ":len_pulses"}, n_len, mp[1]);
    chk({tag, ":tmo_pulses"}, n_tmo, mp[2]);
  endtask
  typedef struct {
    logic [63:0] bytes;
    int          n;
    logic        valid;
    int          len;
    int          errs;
    logic [7:0]  rd0;
  } vec_t;
  vec_t vt [7];
  initial begin
    int c0, e0, kind, len, n;
    logic [7:0] s, b;
    vt[0] = '{64'hA5_03_11_22_33_69_00_00, 6, 1'b1, 3, 0, 8'h11};
    vt[1] = '{64'h5A_00_A5_02_10_20_31_00, 7, 1'b0, 0, 1, 8'h00};
    vt[2] = '{64'hA5_01_FF_00_00_00_00_00, 4, 1'b1, 1, 0, 8'hFF};
    vt[3] = '{64'hA5_00_00_00_00_00_00_00, 2, 1'b0, 0, 1, 8'h00};
    vt[4] = '{64'hA5_11_00_00_00_00_00_00, 2, 1'b0, 0, 1, 8'h00};
    vt[5] = '{64'hA5_A5_00_00_00_00_00_00, 2, 1'b0, 0, 1, 8'h00};
    vt[6] = '{64'hA5_02_A5_10_B7_00_00_00, 5, 1'b1, 2, 0, 8'hA5};
    reset = 1'b1; rx_flag = 1'b0; rx_data = 8'h00; packet_ack = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_rx_clear", int'(rx_clear), 0);
    chk("rst_valid", int'(packet_valid), 0);
    chk("rst_pkt_len", int'(pkt_len), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_overrun", int'(overrun_count), 0);
    chk("rst_errs", int'({err_csum, err_len, err_timeout}), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    reset = 1'b0;
    @(negedge clk);
    for (int v = 0; v < 7; v++) begin
      c0 = n_clr;
      e0 = n_csum + n_len + n_tmo;
      for (int i = 0; i < vt[v].n; i++) send(vt[v].bytes[63-8*i -: 8], 0);
      idle(3);
      chk("vec_valid", int'(packet_valid), int'(vt[v].valid));
      chk("vec_errs", n_csum + n_len + n_tmo - e0, vt[v].errs);
      chk("vec_clears", n_clr - c0, vt[v].n);
      rd_addr = '0;
      #1;
      chk("vec_rd0", int'(rd_data), int'(vt[v].rd0));
      if (vt[v].valid) begin
        chk("vec_len", int'(pkt_len), vt[v].len);
        rd_addr = AW'(vt[v].len);
        #1;
        chk("vec_rd_past_len", int'(rd_data), 0);
      end
      checkpoint("vec");
      if (m_hold) ack();
    end
    send(8'hA5, 0);
    packet_ack = 1'b1;
    send(8'h10, 0);
    s = 8'h10;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      s += b;
      send(b, 0);
    end
    packet_ack = 1'b0;
    send(s, 0);
    idle(2);
    chk("len16_valid", int'(packet_valid), 1);
    chk("len16_len", int'(pkt_len), 16);
    checkpoint("len16");
    c0 = n_clr;
    for (int i = 0; i < 3; i++) send(8'($urandom), 0);
    idle(3);
    chk("ovr_count", int'(overrun_count), 3);
    chk("ovr_clears", n_clr - c0, 3);
    checkpoint("ovr");
    ack();
    send(8'hA5, 0); send(8'h04, 0); send(8'h01, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    chk("rst2_valid", int'(packet_valid), 0);
    chk("rst2_err_count", int'(err_count), 0);
    chk("rst2_overrun", int'(overrun_count), 0);
    chk("rst2_rx_clear", int'(rx_clear), 0);
    chk("rst2_errs", int'({err_csum, err_len, err_timeout}), 0);
    e0 = n_csum + n_len + n_tmo;
    checkpoint("rst2");
    chk("rst2_no_err_pulse", n_csum + n_len + n_tmo - e0, 0);
    e0 = n_tmo;
    send(8'hA5, 0); send(8'h02, 0); send(8'hAA, 0);
    idle(T + 3);
    chk("tmo_silence_pulse", n_tmo - e0, 1);
    checkpoint("tmo_silence");
    e0 = n_tmo;
    send(8'hA5, 0); send(8'h02, 0); send(8'hAA, 0); send(8'hBB, T - 2); send(8'h67, 0);
    idle(3);
    chk("tmo_edge_none", n_tmo - e0, 0);
    chk("tmo_edge_valid", int'(packet_valid), 1);
    checkpoint("tmo_edge");
    ack();
    e0 = n_tmo;
    send(8'hA5, 0); send(8'h02, 0); send(8'hAA, 0); send(8'hBB, T - 1);
    idle(3);
    chk("tmo_late_pulse", n_tmo - e0, 1);
    checkpoint("tmo_late");
    c0 = n_clr;
    e0 = n_len;
    rx_data = 8'hA5;
    rx_flag = 1'b1;
    @(negedge clk);
    m_byte(8'hA5, cyc);
    repeat (49) @(negedge clk);
    chk("flag_held_one_clear", n_clr - c0, 1);
    chk("flag_held_no_len_err", n_len - e0, 0);
    rx_flag = 1'b0;
    @(negedge clk);
    send(8'h01, 0); send(8'h7E, 0); send(8'h7F, 0);
    idle(3);
    chk("flag_held_valid", int'(packet_valid), 1);
    checkpoint("flag_held");
    ack();
    for (int f = 0; f < 100; f++) begin
      kind = int'($urandom_range(0, 4));
      if (kind <= 1) begin
        len = int'($urandom_range(1, MAX_LEN));
        s = 8'(len);
        send(8'hA5, g());
        send(8'(len), g());
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          s += b;
          send(b, g());
        end
        send(kind == 0 ? s : s + 8'($urandom_range(1, 255)), g());
      end else if (kind == 2) begin
        send(8'hA5, g());
        send($urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)), g());
      end else if (kind == 3) begin
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < n; i++) send(8'($urandom), g());
      end else begin
        len = int'($urandom_range(2, MAX_LEN));
        send(8'hA5, 0);
        send(8'(len), 0);
        n = int'($urandom_range(0, len - 1));
        for (int i = 0; i < n; i++) send(8'($urandom), 0);
      end
      if (m_hold && $urandom_range(0, 1) == 1) begin
        n = int'($urandom_range(1, 3));
        for (int i = 0; i < n; i++) send(8'($urandom), g());
      end
      checkpoint("rnd");
      if (m_hold) ack();
      else if ($urandom_range(0, 3) == 0) begin
        packet_ack = 1'b1;
        @(negedge clk);
        packet_ack = 1'b0;
      end
    end
    for (int i = 0; i < 260; i++) begin
      send(8'hA5, 0);
      send(8'h00, 0);
    end
    checkpoint("sat_err");
    chk("err_count_sat", int'(err_count), 255);
    send(8'hA5, 0); send(8'h01, 0); send(8'h55, 0); send(8'h56, 0);
    for (int i = 0; i < 260; i++) send(8'($urandom), 0);
    checkpoint("sat_ovr");
    chk("overrun_sat", int'(overrun_count), 255);
    ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_packet_ctrl.md
Name: uart_rx_packet_ctrl

Overview:
Controller that sequences the UART byte receiver, which exposes an 8-bit data bus, a ready flag and a clear_buffer input.
- Consumes each received byte and pulses the receiver's clear input to re-arm it.
- Frames bytes into packets of the form SYNC, LEN, payload[LEN], CSUM.
- Stores the payload in an internal buffer and presents a complete, checksum-verified packet to the downstream consumer through a valid/ack handshake with random-access read.
- Sits between the UART byte receiver and the command-decode logic.

Parameters:
SYNC_BYTE, 8'hA5, start-of-packet marker.
MAX_LEN, 16, maximum payload bytes; legal LEN is 1..MAX_LEN.
AW, 4, payload read-address width; must satisfy 2^AW >= MAX_LEN.
TIMEOUT_CYCLES, 1_041_600, maximum idle clocks between bytes inside a packet (about 10 byte times at 9600 baud on a 100 MHz clock).

Ports:
clk_100MHZ  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
rx_data  in  8  byte from the receiver (its data_out).
rx_flag  in  1  receiver byte-ready flag (its data_flag).
rx_clear  out  1  one-cycle pulse to the receiver's clear_buffer input.
packet_valid  out  1  a verified packet is held in the buffer.
packet_ack  in  1  consumer releases the packet.
pkt_len  out  AW+1  payload length of the held packet.
rd_addr  in  AW  payload read index.
rd_data  out  8  payload byte at rd_addr (combinational).
err_csum  out  1  one-cycle pulse: checksum mismatch.
err_len  out  1  one-cycle pulse: LEN = 0 or LEN > MAX_LEN.
err_timeout  out  1  one-cycle pulse: inter-byte timeout.
err_count  out  8  total error pulses, saturating at 255.
overrun_count  out  8  bytes dropped while in HOLD, saturating at 255.

Behaviour:
Reset (synchronous, active-high):
- State = IDLE.
- All outputs and counters = 0.
- Internal clr_pending = 0; payload buffer contents are don't-care.
- Reset asserted mid-packet discards the partial packet with no error pulse and no rx_clear.

Byte accept:
- A byte is accepted in cycle N when rx_flag=1 and clr_pending=0.
- rx_clear=1 in cycle N+1 only; clr_pending is set at the end of N.
- clr_pending clears on the first cycle rx_flag is sampled 0.
- Every accepted byte, in any state, produces exactly one rx_clear pulse.

State machine (transitions take effect on the edge ending the accept cycle):
- IDLE: byte == SYNC_BYTE -> LEN; any other byte is discarded silently.
- LEN: byte in 1..MAX_LEN -> store LEN, set csum = byte, idx = 0 -> PAYLOAD. Otherwise pulse err_len and return to IDLE. A SYNC_BYTE arriving here is treated as a length value.
- PAYLOAD: buf[idx] = byte; csum = csum + byte (mod 256); idx++. After the LEN-th byte -> CSUM.
- CSUM: byte == csum -> HOLD, with packet_valid=1 and pkt_len=LEN from cycle N+1. Mismatch -> pulse err_csum, return to IDLE.
- HOLD: packet_valid stays 1 and buffer contents stay frozen.
  - packet_ack=1 -> packet_valid=0 next cycle, state IDLE.
  - Bytes accepted in HOLD are dropped, still cleared, and increment overrun_count.
  - packet_ack while not in HOLD is ignored.

Timeout:
- Counter runs only in LEN, PAYLOAD and CSUM; it resets to 0 on every accepted byte and on state entry.
- On reaching TIMEOUT_CYCLES: pulse err_timeout, go to IDLE.
- If a byte accept and timeout expiry land in the same cycle, the byte wins: it is processed and no timeout is raised.

Error and read outputs:
- Each err_* pulse increments err_count by 1, saturating at 255. Only one err_* can fire per cycle.
- rd_data = buf[rd_addr] when rd_addr < pkt_len and packet_valid=1; otherwise 8'h00.
- rx_clear, err_csum, err_len and err_timeout are registered and never asserted for more than one cycle.

Test Plan:
1. Good packet: bytes A5,03,11,22,33,69 -> packet_valid=1 one cycle after the 0x69 accept; pkt_len=3; rd_addr 0/1/2 -> 11/22/33; rd_addr 3 -> 00; packet_ack -> packet_valid=0 next cycle; six rx_clear pulses total.
2. Bad checksum plus garbage: 5A,00,A5,02,10,20,31 -> 5A and 00 discarded with no error; err_csum single pulse; err_count=1; packet_valid stays 0; a following A5,01,FF,00 is accepted.
3. Length bounds: A5,00 -> err_len; A5,11 (17) -> err_len; A5,10 (16) followed by 16 payload bytes and the correct CSUM -> valid with pkt_len=16; err_count=2.
4. Timeout: A5,02,AA, then silence for TIMEOUT_CYCLES -> err_timeout pulse, state IDLE. A byte landing exactly on the expiry cycle -> no err_timeout and the packet continues.
5. Overrun and reset: hold a valid packet without ack, send 3 bytes -> overrun_count=3, buffer unchanged, 3 rx_clear pulses. Assert reset for 1 cycle mid-PAYLOAD -> all outputs 0, no error pulse.
6. rx_flag held high for 50 cycles after one byte -> exactly one accept and one rx_clear; the next accept occurs only after rx_flag returns to 0.
